// File: rtl/top.sv
// rtl/top.sv - single-cycle CPU-31 MIPS core with instruction ROM, register file and data RAM
module top #(
   parameter string       IMEM_FILE  = "imem.hex",
   parameter int          IMEM_DEPTH = 1024,
   parameter int          DMEM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input logic clk_in,
   input logic rst
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0a;
   localparam logic [5:0] OP_SLTIU   = 6'h0b;
   localparam logic [5:0] OP_ANDI    = 6'h0c;
   localparam logic [5:0] OP_ORI     = 6'h0d;
   localparam logic [5:0] OP_XORI    = 6'h0e;
   localparam logic [5:0] OP_LUI     = 6'h0f;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2b;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;
   localparam logic [5:0] FN_SLTU = 6'h2b;

   // Architectural state; declaration values keep simulation defined before the first reset edge
   logic [31:0] pc = RESET_PC;
   logic [31:0] regs [0:31] = '{default: 32'h0};

   logic [31:0] imem [0:IMEM_DEPTH-1];
   logic [31:0] dmem [0:DMEM_DEPTH-1];

   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] target;

   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] imm_se;
   logic [31:0] imm_ze;
   logic [31:0] pc_plus4;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] mem_addr;
   logic [DAW-1:0] dmem_idx;
   logic [31:0] dmem_rd;

   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        dmem_we;
   logic [31:0] next_pc;

   // Fetch index truncates the PC, so addresses past the ROM wrap around
   assign instr  = imem[pc[IAW+1:2]];
   assign opcode = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign shamt  = instr[10:6];
   assign funct  = instr[5:0];
   assign imm    = instr[15:0];
   assign target = instr[25:0];

   assign rs_val = (rs == 5'd0) ? 32'h0 : regs[rs];
   assign rt_val = (rt == 5'd0) ? 32'h0 : regs[rt];
   assign imm_se = {{16{imm[15]}}, imm};
   assign imm_ze = {16'h0, imm};

   assign pc_plus4      = pc + 32'd4;
   assign branch_target = pc_plus4 + {imm_se[29:0], 2'b00};
   assign jump_target   = {pc_plus4[31:28], target, 2'b00};

   // Word-addressed data RAM; the byte offset bits of the effective address are dropped
   assign mem_addr = rs_val + imm_se;
   assign dmem_idx = mem_addr[DAW+1:2];
   assign dmem_rd  = dmem[dmem_idx];

   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr[31:DAW+2], mem_addr[1:0]};

   // Decode and execute: any encoding not listed falls through as a NOP
   always_comb begin
      wb_en   = 1'b0;
      wb_addr = rd;
      wb_data = 32'h0;
      dmem_we = 1'b0;
      next_pc = pc_plus4;
      case (opcode)
         OP_SPECIAL: begin
            wb_en = 1'b1;
            case (funct)
               FN_ADD, FN_ADDU: wb_data = rs_val + rt_val;
               FN_SUB, FN_SUBU: wb_data = rs_val - rt_val;
               FN_AND:          wb_data = rs_val & rt_val;
               FN_OR:           wb_data = rs_val | rt_val;
               FN_XOR:          wb_data = rs_val ^ rt_val;
               FN_NOR:          wb_data = ~(rs_val | rt_val);
               FN_SLT:          wb_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
               FN_SLTU:         wb_data = {31'h0, rs_val < rt_val};
               FN_SLL:          wb_data = rt_val << shamt;
               FN_SRL:          wb_data = rt_val >> shamt;
               FN_SRA:          wb_data = $signed(rt_val) >>> shamt;
               FN_SLLV:         wb_data = rt_val << rs_val[4:0];
               FN_SRLV:         wb_data = rt_val >> rs_val[4:0];
               FN_SRAV:         wb_data = $signed(rt_val) >>> rs_val[4:0];
               FN_JR: begin
                  wb_en   = 1'b0;
                  next_pc = rs_val;
               end
               default:         wb_en = 1'b0;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            wb_en = 1'b1; wb_addr = rt; wb_data = rs_val + imm_se;
         end
         OP_SLTI: begin
            wb_en = 1'b1; wb_addr = rt; wb_data = {31'h0, $signed(rs_val) < $signed(imm_se)};
         end
         OP_SLTIU: begin
            wb_en = 1'b1; wb_addr = rt; wb_data = {31'h0, rs_val < imm_se};
         end
         OP_ANDI: begin
            wb_en = 1'b1; wb_addr = rt; wb_data = rs_val & imm_ze;
         end
         OP_ORI: begin
            wb_en = 1'b1; wb_addr = rt; wb_data = rs_val | imm_ze;
         end
         OP_XORI: begin
            wb_en = 1'b1; wb_addr = rt; wb_data = rs_val ^ imm_ze;
         end
         OP_LUI: begin
            wb_en = 1'b1; wb_addr = rt; wb_data = {imm, 16'h0};
         end
         OP_LW: begin
            wb_en = 1'b1; wb_addr = rt; wb_data = dmem_rd;
         end
         OP_SW:  dmem_we = 1'b1;
         OP_BEQ: if (rs_val == rt_val) next_pc = branch_target;
         OP_BNE: if (rs_val != rt_val) next_pc = branch_target;
         OP_J:   next_pc = jump_target;
         OP_JAL: begin
            wb_en = 1'b1; wb_addr = 5'd31; wb_data = pc_plus4; next_pc = jump_target;
         end
         default: ;
      endcase
   end

   // PC and register file commit; reset discards the in-flight instruction's write
   always_ff @(posedge clk_in) begin
      if (rst) begin
         pc <= RESET_PC;
         for (int i = 1; i < 32; i++) regs[i] <= 32'h0;
      end else begin
         pc <= next_pc;
         if (wb_en && (wb_addr != 5'd0)) regs[wb_addr] <= wb_data;
      end
   end

   // Data RAM store port; contents survive reset but a store under reset is dropped
   always_ff @(posedge clk_in) begin
      if (!rst && dmem_we) dmem[dmem_idx] <= rt_val;
   end
endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - scoreboard bench for the CPU-31 core against an instruction-level reference model
module tb_top;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   top #(.IMEM_FILE("")) dut (.clk_in(clk), .rst(rst));

   typedef enum {M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
                 M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_ADDI, M_ADDIU, M_ANDI,
                 M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_SLTI, M_SLTIU, M_J, M_JAL,
                 M_BADOP, M_BADFN} mn_t;

   typedef struct {
      mn_t         mn;
      logic [4:0]  rs, rt, rd, sh;
      logic [15:0] imm;
      logic [25:0] tgt;
   } ins_t;

   typedef struct packed {
      logic [31:0]       pc;
      logic [31:0][31:0] r;
   } exp_t;

   ins_t        prog [1024];
   logic [31:0] m_pc;
   logic [31:0] m_regs [32];
   logic [31:0] m_dmem [int];
   exp_t        q [$];
   int          n_checks = 0;
   int          n_pass   = 0;
   bit          run      = 1'b0;
   string       tag      = "";
   int          step_no  = 0;

   function automatic ins_t mk(mn_t m, int rs, int rt, int rd, int sh, int imm, int tgt);
      ins_t i;
      i.mn = m; i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd); i.sh = 5'(sh);
      i.imm = 16'(imm); i.tgt = 26'(tgt);
      return i;
   endfunction
   function automatic ins_t R(mn_t m, int rd, int rs, int rt);  return mk(m, rs, rt, rd, 0, 0, 0); endfunction
   function automatic ins_t SH(mn_t m, int rd, int rt, int sh); return mk(m, 0, rt, rd, sh, 0, 0); endfunction
   function automatic ins_t I(mn_t m, int rt, int rs, int imm); return mk(m, rs, rt, 0, 0, imm, 0); endfunction
   function automatic ins_t J(mn_t m, int tgt);                 return mk(m, 0, 0, 0, 0, 0, tgt); endfunction

   // MIPS32 machine encoding of one mnemonic
   function automatic logic [31:0] enc(ins_t i);
      logic [5:0] fn, op;
      bit rtype;
      rtype = 1'b1; fn = 6'h00; op = 6'h00;
      case (i.mn)
         M_ADD: fn = 6'h20;  M_ADDU: fn = 6'h21; M_SUB: fn = 6'h22;  M_SUBU: fn = 6'h23;
         M_AND: fn = 6'h24;  M_OR:   fn = 6'h25; M_XOR: fn = 6'h26;  M_NOR:  fn = 6'h27;
         M_SLT: fn = 6'h2a;  M_SLTU: fn = 6'h2b; M_SLL: fn = 6'h00;  M_SRL:  fn = 6'h02;
         M_SRA: fn = 6'h03;  M_SLLV: fn = 6'h04; M_SRLV: fn = 6'h06; M_SRAV: fn = 6'h07;
         M_JR:  fn = 6'h08;  M_BADFN: fn = 6'h3f;
         default: rtype = 1'b0;
      endcase
      case (i.mn)
         M_ADDI: op = 6'h08; M_ADDIU: op = 6'h09; M_SLTI: op = 6'h0a; M_SLTIU: op = 6'h0b;
         M_ANDI: op = 6'h0c; M_ORI:   op = 6'h0d; M_XORI: op = 6'h0e; M_LUI:   op = 6'h0f;
         M_LW:   op = 6'h23; M_SW:    op = 6'h2b; M_BEQ:  op = 6'h04; M_BNE:   op = 6'h05;
         M_J:    op = 6'h02; M_JAL:   op = 6'h03; M_BADOP: op = 6'h3f;
         default: ;
      endcase
      if (rtype) return {6'h00, i.rs, i.rt, i.rd, i.sh, fn};
      if (i.mn == M_J || i.mn == M_JAL) return {op, i.tgt};
      return {op, i.rs, i.rt, i.imm};
   endfunction

   function automatic void wr(int r, logic [31:0] v);
      if (r != 0) m_regs[r] = v;
   endfunction

   // Reference model: executes one instruction from its mnemonic
   task automatic m_step();
      ins_t i;
      logic [31:0] a, b, se, ze, npc, ad;
      i   = prog[m_pc[11:2]];
      a   = m_regs[i.rs];
      b   = m_regs[i.rt];
      se  = {{16{i.imm[15]}}, i.imm};
      ze  = {16'h0, i.imm};
      npc = m_pc + 32'd4;
      ad  = a + se;
      case (i.mn)
         M_ADD, M_ADDU: wr(i.rd, a + b);
         M_SUB, M_SUBU: wr(i.rd, a - b);
         M_AND:   wr(i.rd, a & b);
         M_OR:    wr(i.rd, a | b);
         M_XOR:   wr(i.rd, a ^ b);
         M_NOR:   wr(i.rd, ~(a | b));
         M_SLT:   wr(i.rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
         M_SLTU:  wr(i.rd, (a < b) ? 32'd1 : 32'd0);
         M_SLL:   wr(i.rd, b << i.sh);
         M_SRL:   wr(i.rd, b >> i.sh);
         M_SRA:   wr(i.rd, 32'($signed(b) >>> i.sh));
         M_SLLV:  wr(i.rd, b << a[4:0]);
         M_SRLV:  wr(i.rd, b >> a[4:0]);
         M_SRAV:  wr(i.rd, 32'($signed(b) >>> a[4:0]));
         M_JR:    npc = a;
         M_ADDI, M_ADDIU: wr(i.rt, a + se);
         M_SLTI:  wr(i.rt, ($signed(a) < $signed(se)) ? 32'd1 : 32'd0);
         M_SLTIU: wr(i.rt, (a < se) ? 32'd1 : 32'd0);
         M_ANDI:  wr(i.rt, a & ze);
         M_ORI:   wr(i.rt, a | ze);
         M_XORI:  wr(i.rt, a ^ ze);
         M_LUI:   wr(i.rt, {i.imm, 16'h0});
         M_LW:    wr(i.rt, m_dmem.exists(int'(ad[11:2])) ? m_dmem[int'(ad[11:2])] : 32'hx);
         M_SW:    m_dmem[int'(ad[11:2])] = b;
         M_BEQ:   if (a == b) npc = npc + (se << 2);
         M_BNE:   if (a != b) npc = npc + (se << 2);
         M_J:     npc = {npc[31:28], i.tgt, 2'b00};
         M_JAL: begin
            wr(31, npc);
            npc = {npc[31:28], i.tgt, 2'b00};
         end
         default: ;
      endcase
      m_pc = npc;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic clear_prog();
      for (int k = 0; k < 1024; k++) prog[k] = SH(M_SLL, 0, 0, 0);
   endtask

   // Load the ROM under reset, pulse one edge and check the reset state
   task automatic start(string t);
      int bad;
      rst = 1'b1; run = 1'b0; tag = t;
      for (int k = 0; k < 1024; k++) dut.imem[k] = enc(prog[k]);
      m_pc = 32'h0;
      for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
      @(posedge clk); #2;
      chk({t, " reset pc"}, dut.pc, 32'h0);
      bad = 0;
      for (int k = 0; k < 32; k++) if (dut.regs[k] !== 32'h0) begin bad = k; break; end
      chk({t, " reset regs"}, dut.regs[bad], 32'h0);
   endtask

   // Queue the expected state after each instruction, release reset and let the monitor drain
   task automatic go(int steps);
      exp_t e;
      int t;
      step_no = 0;
      for (int s = 0; s < steps; s++) begin
         m_step();
         e.pc = m_pc;
         for (int k = 0; k < 32; k++) e.r[k] = m_regs[k];
         q.push_back(e);
      end
      rst = 1'b0; run = 1'b1;
      t = 0;
      while (q.size() != 0 && t < steps + 16) begin
         @(posedge clk); #2;
         t++;
      end
      chk({tag, " drain"}, 32'(q.size()), 32'h0);
      q.delete();
      run = 1'b0;
   endtask

   function automatic ins_t rnd_ins(int idx);
      mn_t m;
      int rd, rs, rt;
      rd = $urandom_range(0, 7); rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
      m = mn_t'($urandom_range(0, 32));
      case (m)
         M_JR:                 return R(M_ADDU, rd, rs, rt);
         M_SLL, M_SRL, M_SRA:  return SH(m, rd, rt, $urandom_range(0, 31));
         M_ADDI, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_SLTI, M_SLTIU:
                               return I(m, rt, rs, $urandom_range(0, 65535));
         M_LW, M_SW:           return I(m, rt, 0, $urandom_range(0, 7) * 4 + $urandom_range(0, 3));
         M_BEQ, M_BNE:         return I(m, rt, rs, $urandom_range(0, 2));
         M_J, M_JAL:           return J(m, idx + 1 + $urandom_range(0, 2));
         M_BADOP, M_BADFN:     return mk(m, rs, rt, rd, $urandom_range(0, 31), $urandom_range(0, 65535), 0);
         default:              return R(m, rd, rs, rt);
      endcase
   endfunction

   // Monitor: after every edge compare the retired state with the next queued expectation
   initial begin
      exp_t e;
      int bad;
      forever begin
         @(posedge clk); #1;
         if (run && q.size() != 0) begin
            e = q.pop_front();
            step_no++;
            chk($sformatf("%s step %0d pc", tag, step_no), dut.pc, e.pc);
            bad = 0;
            for (int k = 0; k < 32; k++) if (dut.regs[k] !== e.r[k]) begin bad = k; break; end
            chk($sformatf("%s step %0d $%0d", tag, step_no, bad), dut.regs[bad], e.r[bad]);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL global timeout");
      $fatal(1);
   end

   initial begin
      clear_prog();
      prog[0] = I(M_ADDI, 1, 0, 7);
      prog[1] = mk(M_BADOP, 1, 2, 3, 4, 5, 0);
      prog[2] = mk(M_BADFN, 1, 1, 3, 0, 0, 0);
      start("nop"); go(4);
      chk("nop pc", dut.pc, 32'h10);
      chk("nop $1", dut.regs[1], 32'd7);
      chk("nop $2", dut.regs[2], 32'd0);
      chk("nop $3", dut.regs[3], 32'd0);

      clear_prog();
      prog[0] = I(M_ADDI, 1, 0, 5);
      prog[1] = I(M_ADDI, 2, 0, -3);
      prog[2] = R(M_ADD, 3, 1, 2);
      prog[3] = R(M_SUB, 4, 2, 1);
      prog[4] = R(M_SLT, 5, 2, 1);
      prog[5] = R(M_SLTU, 6, 2, 1);
      start("arith"); go(6);
      chk("arith $3", dut.regs[3], 32'd2);
      chk("arith $4", dut.regs[4], 32'hFFFF_FFF8);
      chk("arith $5", dut.regs[5], 32'd1);
      chk("arith $6", dut.regs[6], 32'd0);

      clear_prog();
      prog[0] = I(M_LUI, 1, 0, 16'h8000);
      prog[1] = I(M_ORI, 1, 1, 16'h00F0);
      prog[2] = SH(M_SRA, 2, 1, 4);
      prog[3] = SH(M_SRL, 3, 1, 4);
      prog[4] = R(M_NOR, 4, 0, 0);
      prog[5] = I(M_ADDI, 0, 0, 7);
      start("logic"); go(6);
      chk("logic $2", dut.regs[2], 32'hF800_000F);
      chk("logic $3", dut.regs[3], 32'h0800_000F);
      chk("logic $4", dut.regs[4], 32'hFFFF_FFFF);
      chk("logic $0", dut.regs[0], 32'h0);

      clear_prog();
      prog[0] = I(M_ADDI, 1, 0, 16'h12);
      prog[1] = I(M_SW, 1, 0, 8);
      prog[2] = I(M_LW, 2, 0, 8);
      start("mem"); go(3);
      chk("mem $2", dut.regs[2], 32'h12);
      chk("mem dmem[2]", dut.dmem[2], 32'h12);

      clear_prog();
      prog[0]  = I(M_ADDI, 1, 0, 1);
      prog[1]  = I(M_BEQ, 1, 1, 1);
      prog[2]  = I(M_ADDI, 2, 0, 16'h0BAD);
      prog[3]  = I(M_BNE, 1, 1, 5);
      prog[4]  = I(M_ADDI, 3, 0, 3);
      prog[5]  = J(M_JAL, 16);
      prog[6]  = I(M_ADDI, 5, 0, 5);
      prog[16] = I(M_ADDI, 4, 0, 4);
      prog[17] = R(M_JR, 0, 31, 0);
      start("branch"); go(8);
      chk("branch $2", dut.regs[2], 32'h0);
      chk("branch $3", dut.regs[3], 32'd3);
      chk("branch $4", dut.regs[4], 32'd4);
      chk("branch $5", dut.regs[5], 32'd5);
      chk("branch $31", dut.regs[31], 32'h18);
      chk("branch pc", dut.pc, 32'h1C);

      clear_prog();
      prog[0]    = J(M_J, 1023);
      prog[1023] = I(M_ADDI, 5, 0, 9);
      start("wrap"); go(4);
      chk("wrap $5", dut.regs[5], 32'd9);
      chk("wrap pc", dut.pc, 32'h1000);

      clear_prog();
      prog[0] = I(M_ADDI, 1, 1, 1);
      prog[1] = I(M_SW, 1, 0, 0);
      prog[2] = J(M_J, 0);
      start("midrst"); go(10);
      chk("midrst pre pc", dut.pc, 32'h4);
      chk("midrst pre $1", dut.regs[1], 32'd4);
      rst = 1'b1;
      @(posedge clk); #2;
      chk("midrst pc", dut.pc, 32'h0);
      chk("midrst $1", dut.regs[1], 32'h0);
      chk("midrst dmem[0]", dut.dmem[0], 32'd3);

      for (int p = 0; p < 5; p++) begin
         clear_prog();
         for (int k = 0; k < 8; k++) prog[k] = I(M_SW, 0, 0, k * 4);
         for (int k = 8; k < 48; k++) prog[k] = rnd_ins(k);
         start($sformatf("rand%0d", p)); go(48);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
